// File: rtl/mask_index_encoder.sv
// mask_index_encoder
// Takes an N-bit mask and emits the index of each set bit, lowest first,
// one index per out_valid/out_ready handshake. A new mask is taken only
// while idle. abort throws away whatever is left of the current mask.

module mask_index_encoder #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_mask,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_index,
    output logic           out_last,
    output logic [W:0]     remaining,
    output logic           empty_pulse
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   pending;
    logic [N-1:0]   pending_next;
    logic [W:0]     remaining_next;
    logic           empty_next;
    logic           in_ready_next;
    logic [W:0]     mask_count;
    logic [W-1:0]   lowest_index;

    // Count the set bits of the incoming mask; this becomes the initial remaining count
    always_comb begin
        mask_count = '0;
        for (int i = 0; i < N; i++) begin
            mask_count = mask_count + (W+1)'(in_mask[i]);
        end
    end

    // Find the lowest set bit of the pending mask; scanning downward lets the lowest one win
    always_comb begin
        lowest_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lowest_index = W'(i);
            end
        end
    end

    // Next-state logic: accept masks while idle, retire one bit per handshake while draining
    always_comb begin
        state_next     = state;
        pending_next   = pending;
        remaining_next = remaining;
        empty_next     = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (in_mask != '0) begin
                        pending_next   = in_mask;
                        remaining_next = mask_count;
                        state_next     = DRAIN;
                    end else begin
                        empty_next = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    pending_next   = '0;
                    remaining_next = '0;
                    state_next     = IDLE;
                end else if (out_ready) begin
                    pending_next   = pending & (pending - N'(1));
                    remaining_next = remaining - (W+1)'(1);
                    if (remaining == (W+1)'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                pending_next   = '0;
                remaining_next = '0;
            end
        endcase

        in_ready_next = (state_next == IDLE);
    end

    // State and datapath registers; in_ready stays low until the first edge after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            remaining   <= '0;
            empty_pulse <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            remaining   <= remaining_next;
            empty_pulse <= empty_next;
            in_ready    <= in_ready_next;
        end
    end

    assign out_valid = (state == DRAIN);
    assign out_index = lowest_index;
    assign out_last  = (state == DRAIN) && (remaining == (W+1)'(1));

endmodule

// File: tb/tb_mask_index_encoder.sv
// tb_mask_index_encoder
// Scoreboard bench: each accepted mask pushes its expected index sequence,
// a negedge monitor compares whatever the encoder presents.

module tb_mask_index_encoder;

    localparam int N = 32;
    localparam int W = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   in_mask = '0;
    logic           abort = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_index;
    logic           out_last;
    logic [W:0]     remaining;
    logic           empty_pulse;

    typedef struct {
        logic [W-1:0] idx;
        logic         last;
        logic [W:0]   rem;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;

    mask_index_encoder #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mask     (in_mask),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .out_last    (out_last),
        .remaining   (remaining),
        .empty_pulse (empty_pulse)
    );

    always #5 clk = ~clk;

    // Record one comparison and report it if it differs
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: list every set bit lowest first with the count still owed
    function automatic void pushMask(input logic [N-1:0] m);
        int   total;
        int   k;
        exp_t e;
        total = $countones(m);
        k = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                e.idx  = W'(i);
                e.rem  = (W+1)'(total - k);
                e.last = (k == total - 1);
                sb.push_back(e);
                k++;
            end
        end
    endfunction

    // Random consumer back-pressure when enabled
    always begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: compare every presented index against the head of the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                compared++;
                errors++;
                $display("[TB] FAIL unexpected_output: got index %0d with nothing expected at %0t", out_index, $time);
            end else begin
                checkOutput("out_index", 64'(out_index), 64'(sb[0].idx));
                checkOutput("out_last", 64'(out_last), 64'(sb[0].last));
                checkOutput("remaining", 64'(remaining), 64'(sb[0].rem));
                if (abort) sb.delete();
                else if (out_ready) void'(sb.pop_front());
            end
        end
    end

    // Offer a mask, wait (bounded) for acceptance, then check the first-cycle response
    task automatic applyStimulus(input logic [N-1:0] m);
        int waited = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        in_mask  = m;
        pushMask(m);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (m != '0) begin
            checkOutput("latency_out_valid", 64'(out_valid), 64'd1);
        end else begin
            checkOutput("empty_pulse_set", 64'(empty_pulse), 64'd1);
            checkOutput("empty_no_valid", 64'(out_valid), 64'd0);
            checkOutput("empty_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            checkOutput("empty_pulse_clear", 64'(empty_pulse), 64'd0);
            checkOutput("empty_no_valid2", 64'(out_valid), 64'd0);
        end
    endtask

    // Wait (bounded) until every expected index has been seen and the block is idle
    task automatic waitIdle();
        int waited = 0;
        while ((sb.size() != 0 || !in_ready) && waited < 500) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("drain_done", 64'(sb.size() == 0 && in_ready), 64'd1);
    endtask

    initial begin
        logic [N-1:0] m;

        // Reset behaviour before any clock edge
        #2;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_remaining", 64'(remaining), 64'd0);
        checkOutput("reset_out_index", 64'(out_index), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_edge", 64'(in_ready), 64'd1);

        // Three-bit mask at full rate including bit 31
        out_ready = 1'b1;
        applyStimulus(32'h8000_0011);
        waitIdle();
        checkOutput("in_ready_after_last", 64'(in_ready), 64'd1);

        // Stalled consumer holds outputs; in_valid during drain is ignored
        out_ready = 1'b0;
        applyStimulus(32'h0000_0006);
        in_valid = 1'b1;
        in_mask  = 32'h0000_00FF;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("stall_index", 64'(out_index), 64'd1);
        checkOutput("stall_remaining", 64'(remaining), 64'd2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitIdle();

        // Empty mask produces only the pulse
        applyStimulus('0);

        // All-ones mask aborted after two indices, abort alongside out_ready
        out_ready = 1'b1;
        applyStimulus(32'hFFFF_FFFF);
        checkOutput("full_remaining", 64'(remaining), 64'd32);
        @(posedge clk);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_remaining", 64'(remaining), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a drain
        applyStimulus(32'h0000_00F0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("async_rst_remaining", 64'(remaining), 64'd0);
        checkOutput("async_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(32'h0000_0001);
        waitIdle();

        // Randomized masks with random back-pressure
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: m = $urandom;
                1: m = $urandom & $urandom & $urandom;
                2: m = N'(1) << $urandom_range(0, N - 1);
                default: m = ~(N'(1) << $urandom_range(0, N - 1));
            endcase
            applyStimulus(m);
            waitIdle();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule
